// File: rtl/execute_stage.sv
// Execute stage of an in-order pipeline: ID/EX register, operand forwarding,
// ALU and EX/MEM register.
module execute_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bubble,
   input  logic [DATA_W-1:0] dataReg1,
   input  logic [DATA_W-1:0] dataReg2,
   input  logic [6:0]        opCodeIn,
   input  logic [4:0]        rs1AddrIn,
   input  logic [4:0]        rs2AddrIn,
   input  logic [4:0]        writeBackAddrIn,
   input  logic [4:0]        aluOpIn,
   input  logic [DATA_W-1:0] immIn,
   input  logic [2:0]        dataCacheControlIn,
   input  logic              regWriteEnableIn,
   input  logic [1:0]        select1,
   input  logic [1:0]        select2,
   input  logic [DATA_W-1:0] memWbData,
   output logic [6:0]        opCodeToHazard,
   output logic [4:0]        exRs1Addr,
   output logic [4:0]        exRs2Addr,
   output logic [4:0]        exWriteBackAddr,
   output logic [DATA_W-1:0] aluResult,
   output logic [DATA_W-1:0] memData,
   output logic [DATA_W-1:0] memRs2Data,
   output logic [2:0]        memDataCacheControl,
   output logic              memWriteEnable,
   output logic [4:0]        memWriteBackAddr
);

   logic [DATA_W-1:0] ex_data1;
   logic [DATA_W-1:0] ex_data2;
   logic [4:0]        ex_alu_op;
   logic [DATA_W-1:0] ex_imm;
   logic [2:0]        ex_cache_ctrl;
   logic              ex_wen;

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] op_b;
   logic [4:0]        shamt;
   logic [DATA_W-1:0] alu_out;

   // Reset wins over bubble; a bubble is an all-zero NOP (no write, no access).
   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         ex_data1        <= '0;
         ex_data2        <= '0;
         opCodeToHazard  <= '0;
         exRs1Addr       <= '0;
         exRs2Addr       <= '0;
         exWriteBackAddr <= '0;
         ex_alu_op       <= '0;
         ex_imm          <= '0;
         ex_cache_ctrl   <= '0;
         ex_wen          <= 1'b0;
      end else begin
         ex_data1        <= dataReg1;
         ex_data2        <= dataReg2;
         opCodeToHazard  <= opCodeIn;
         exRs1Addr       <= rs1AddrIn;
         exRs2Addr       <= rs2AddrIn;
         exWriteBackAddr <= writeBackAddrIn;
         ex_alu_op       <= aluOpIn;
         ex_imm          <= immIn;
         ex_cache_ctrl   <= dataCacheControlIn;
         ex_wen          <= regWriteEnableIn;
      end
   end

   always_comb begin
      op_a = '0;
      case (select1)
         2'd0:    op_a = ex_data1;
         2'd1:    op_a = memData;
         2'd2:    op_a = memWbData;
         default: op_a = '0;
      endcase
   end

   always_comb begin
      fwd_b = '0;
      case (select2)
         2'd0:    fwd_b = ex_data2;
         2'd1:    fwd_b = memData;
         2'd2:    fwd_b = memWbData;
         default: fwd_b = '0;
      endcase
   end

   assign op_b  = ex_alu_op[4] ? ex_imm : fwd_b;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_out = '0;
      case (ex_alu_op[3:0])
         4'd0:    alu_out = op_a + op_b;
         4'd1:    alu_out = op_a - op_b;
         4'd2:    alu_out = op_a & op_b;
         4'd3:    alu_out = op_a | op_b;
         4'd4:    alu_out = op_a ^ op_b;
         4'd5:    alu_out = op_a << shamt;
         4'd6:    alu_out = op_a >> shamt;
         4'd7:    alu_out = $signed(op_a) >>> shamt;
         4'd8:    alu_out = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'd9:    alu_out = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
         4'd10:   alu_out = op_b;
         default: alu_out = '0;
      endcase
   end

   assign aluResult = alu_out;

   // Stores take their data from forwarded B, never from the immediate.
   always_ff @(posedge clk) begin
      if (reset) begin
         memData             <= '0;
         memRs2Data          <= '0;
         memDataCacheControl <= '0;
         memWriteEnable      <= 1'b0;
         memWriteBackAddr    <= '0;
      end else begin
         memData             <= alu_out;
         memRs2Data          <= fwd_b;
         memDataCacheControl <= ex_cache_ctrl;
         memWriteEnable      <= ex_wen;
         memWriteBackAddr    <= exWriteBackAddr;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized scoreboard bench for execute_stage: a behavioural model predicts
// every ALU, ID/EX and EX/MEM value; a separate monitor compares them.
module tb_execute_stage;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          bubble;
   logic [W-1:0]  dataReg1, dataReg2, immIn, memWbData;
   logic [6:0]    opCodeIn;
   logic [4:0]    rs1AddrIn, rs2AddrIn, writeBackAddrIn, aluOpIn;
   logic [2:0]    dataCacheControlIn;
   logic          regWriteEnableIn;
   logic [1:0]    select1, select2;
   logic [6:0]    opCodeToHazard;
   logic [4:0]    exRs1Addr, exRs2Addr, exWriteBackAddr;
   logic [W-1:0]  aluResult, memData, memRs2Data;
   logic [2:0]    memDataCacheControl;
   logic          memWriteEnable;
   logic [4:0]    memWriteBackAddr;

   execute_stage #(.DATA_W(W)) dut (
      .clk(clk), .reset(reset), .bubble(bubble),
      .dataReg1(dataReg1), .dataReg2(dataReg2), .opCodeIn(opCodeIn),
      .rs1AddrIn(rs1AddrIn), .rs2AddrIn(rs2AddrIn), .writeBackAddrIn(writeBackAddrIn),
      .aluOpIn(aluOpIn), .immIn(immIn), .dataCacheControlIn(dataCacheControlIn),
      .regWriteEnableIn(regWriteEnableIn), .select1(select1), .select2(select2),
      .memWbData(memWbData), .opCodeToHazard(opCodeToHazard), .exRs1Addr(exRs1Addr),
      .exRs2Addr(exRs2Addr), .exWriteBackAddr(exWriteBackAddr), .aluResult(aluResult),
      .memData(memData), .memRs2Data(memRs2Data), .memDataCacheControl(memDataCacheControl),
      .memWriteEnable(memWriteEnable), .memWriteBackAddr(memWriteBackAddr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Expected-value queues: ALU result per EX cycle, EX/MEM and ID/EX per edge.
   logic [W-1:0]     alu_q[$];
   logic [2*W+8:0]   exp_q[$];
   logic [21:0]      idex_q[$];

   // Model of the instruction sitting in EX and of the EX/MEM contents.
   logic [W-1:0] s_d1 = '0, s_d2 = '0, s_imm = '0;
   logic [6:0]   s_opc = '0;
   logic [4:0]   s_r1 = '0, s_r2 = '0, s_rd = '0, s_aop = '0;
   logic [2:0]   s_ctl = '0;
   logic         s_wen = 1'b0;
   logic [W-1:0] m_data = '0, m_rs2 = '0;
   logic [2:0]   m_ctl = '0;
   logic         m_wen = 1'b0;
   logic [4:0]   m_rd = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] own,
                                         input logic [W-1:0] mem, input logic [W-1:0] wb);
      if (sel == 2'd0) return own;
      if (sel == 2'd1) return mem;
      if (sel == 2'd2) return wb;
      return '0;
   endfunction

   function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint signed sa, sb;
      int unsigned   sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      if (op == 0)  return W'(a + b);
      if (op == 1)  return W'(a - b);
      if (op == 2)  return a & b;
      if (op == 3)  return a | b;
      if (op == 4)  return a ^ b;
      if (op == 5)  return W'(a << sh);
      if (op == 6)  return a >> sh;
      if (op == 7)  return W'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      if (op == 8)  return (sa < sb) ? W'(1) : W'(0);
      if (op == 9)  return (a < b) ? W'(1) : W'(0);
      if (op == 10) return b;
      return '0;
   endfunction

   // One cycle: new ID-stage inputs plus forwarding controls for the EX instruction.
   task automatic drive(input logic rst, input logic bub, input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input logic [6:0] opc, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [4:0] aop, input logic [W-1:0] imm,
                        input logic [2:0] ctl, input logic wen, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [W-1:0] wb);
      logic [W-1:0] a, fb, b, res;
      @(negedge clk);
      reset = rst; bubble = bub; dataReg1 = d1; dataReg2 = d2; opCodeIn = opc;
      rs1AddrIn = r1; rs2AddrIn = r2; writeBackAddrIn = rd; aluOpIn = aop; immIn = imm;
      dataCacheControlIn = ctl; regWriteEnableIn = wen; select1 = s1; select2 = s2; memWbData = wb;
      a   = pick(s1, s_d1, m_data, wb);
      fb  = pick(s2, s_d2, m_data, wb);
      b   = s_aop[4] ? s_imm : fb;
      res = ref_alu(s_aop[3:0], a, b);
      alu_q.push_back(res);
      if (rst) begin
         m_data = '0; m_rs2 = '0; m_ctl = '0; m_wen = 1'b0; m_rd = '0;
      end else begin
         m_data = res; m_rs2 = fb; m_ctl = s_ctl; m_wen = s_wen; m_rd = s_rd;
      end
      exp_q.push_back({m_data, m_rs2, m_ctl, m_wen, m_rd});
      if (rst || bub) begin
         s_d1 = '0; s_d2 = '0; s_imm = '0; s_opc = '0; s_r1 = '0; s_r2 = '0;
         s_rd = '0; s_aop = '0; s_ctl = '0; s_wen = 1'b0;
      end else begin
         s_d1 = d1; s_d2 = d2; s_imm = imm; s_opc = opc; s_r1 = r1; s_r2 = r2;
         s_rd = rd; s_aop = aop; s_ctl = ctl; s_wen = wen;
      end
      idex_q.push_back({s_opc, s_r1, s_r2, s_rd});
   endtask

   // Monitor: aluResult just after the EX inputs settle, registers just after each edge.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (alu_q.size() > 0) begin
            e = alu_q.pop_front();
            check("aluResult", aluResult, e);
         end
      end
   end

   initial begin
      logic [2*W+8:0] e;
      logic [21:0]    i;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("memData", memData, e[2*W+8:W+9]);
            check("memRs2Data", memRs2Data, e[W+8:9]);
            check("memDataCacheControl", W'(memDataCacheControl), W'(e[8:6]));
            check("memWriteEnable", W'(memWriteEnable), W'(e[5]));
            check("memWriteBackAddr", W'(memWriteBackAddr), W'(e[4:0]));
         end
         if (idex_q.size() > 0) begin
            i = idex_q.pop_front();
            check("opCodeToHazard", W'(opCodeToHazard), W'(i[21:15]));
            check("exRs1Addr", W'(exRs1Addr), W'(i[14:10]));
            check("exRs2Addr", W'(exRs2Addr), W'(i[9:5]));
            check("exWriteBackAddr", W'(exWriteBackAddr), W'(i[4:0]));
         end
      end
   end

   initial begin
      int waited;
      logic [4:0] aop;
      reset = 1'b1; bubble = 1'b0; dataReg1 = '0; dataReg2 = '0; opCodeIn = '0;
      rs1AddrIn = '0; rs2AddrIn = '0; writeBackAddrIn = '0; aluOpIn = '0; immIn = '0;
      dataCacheControlIn = '0; regWriteEnableIn = 1'b0; select1 = '0; select2 = '0; memWbData = '0;

      // Directed: reset, add/forward, immediates, compares, bubble, reset+bubble.
      drive(1, 0, 0, 0, 7'h00, 0, 0, 0, 5'h00, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 5, 7, 7'h33, 1, 2, 3, 5'h00, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 100, 1, 7'h33, 3, 2, 4, 5'h00, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 32'h1000, 32'h99, 7'h23, 4, 9, 0, 5'h10, 8, 2, 0, 1, 0, 0);
      drive(0, 0, 32'hFFFF_FFFF, 0, 7'h13, 5, 0, 6, 5'h10, 1, 0, 1, 0, 2, 32'h55);
      drive(0, 0, 32'h8000_0000, 0, 7'h13, 6, 0, 7, 5'h17, 4, 0, 1, 0, 0, 0);
      drive(0, 0, 32'hFFFF_FFFF, 1, 7'h33, 7, 8, 9, 5'h08, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 32'hFFFF_FFFF, 1, 7'h33, 7, 8, 10, 5'h09, 0, 0, 1, 0, 0, 0);
      drive(0, 1, 32'h1234, 32'h5678, 7'h33, 1, 1, 11, 5'h00, 0, 1, 1, 0, 0, 0);
      drive(0, 0, 3, 4, 7'h33, 2, 3, 12, 5'h00, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 9, 9, 7'h33, 3, 3, 13, 5'h01, 0, 2, 1, 0, 0, 0);
      drive(1, 1, 9, 9, 7'h33, 3, 3, 14, 5'h00, 0, 2, 1, 0, 0, 0);
      drive(0, 0, 1, 2, 7'h33, 1, 2, 15, 5'h00, 0, 0, 1, 0, 0, 0);

      // Randomized stream with occasional bubbles and resets.
      for (int n = 0; n < 500; n++) begin
         aop = 5'($urandom_range(0, 31));
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
               $urandom, (n % 3 == 0) ? W'($urandom_range(0, 40)) : $urandom,
               7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), aop,
               (n % 2 == 0) ? W'($urandom_range(0, 40)) : $urandom,
               3'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), $urandom);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      waited = 0;
      while ((alu_q.size() + exp_q.size() + idex_q.size()) > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      #3;
      if ((alu_q.size() + exp_q.size() + idex_q.size()) > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", alu_q.size() + exp_q.size() + idex_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
